// File: rtl/rename_pkg.sv
// Rename-stage shared types and sizing: physical register tags and
// free-list pointers, used by the free list, ROB and map table.
package rename_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int FL_IDX_W  = $clog2(FL_DEPTH);
    localparam int FL_PTR_W  = FL_IDX_W + 1;
    localparam int FL_CNT_W  = $clog2(FL_DEPTH + 1);

    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

    // Wrap bit set, index zero: a tail this far ahead of head means full.
    localparam fl_ptr_t FL_PTR_FULL = {1'b1, {FL_IDX_W{1'b0}}};

    // Index wraps at FL_DEPTH (not necessarily a power of two); the MSB toggles on wrap.
    function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
        logic [FL_IDX_W-1:0] idx;
        idx = p[FL_IDX_W-1:0];
        if (idx == FL_IDX_W'(FL_DEPTH - 1))
            return {~p[FL_IDX_W], {FL_IDX_W{1'b0}}};
        else
            return {p[FL_IDX_W], idx + FL_IDX_W'(1)};
    endfunction

    function automatic logic [FL_CNT_W-1:0] fl_count(input fl_ptr_t tail, input fl_ptr_t head);
        int unsigned t;
        int unsigned h;
        t = 32'(tail[FL_IDX_W-1:0]);
        h = 32'(head[FL_IDX_W-1:0]);
        if (tail[FL_IDX_W] == head[FL_IDX_W])
            return FL_CNT_W'(t - h);
        else
            return FL_CNT_W'(32'(FL_DEPTH) + t - h);
    endfunction

endpackage

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register tags. Dispatch pops from head,
// commit pushes superseded tags at tail; flush rewinds head to cmt_head.
module phys_reg_freelist
    import rename_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    output preg_t               alloc_preg,
    output logic                freelist_empty,
    output logic [FL_CNT_W-1:0] free_count,
    input  logic                commit_valid,
    input  logic                commit_has_rd,
    input  preg_t               commit_old_preg,
    input  logic                flush
);

    preg_t   mem [FL_DEPTH];
    fl_ptr_t head;
    fl_ptr_t cmt_head;
    fl_ptr_t tail;

    logic do_push;
    logic do_pop;

    // Outputs depend only on registered state: a tag pushed this cycle is
    // not visible to alloc_preg / freelist_empty until the next cycle.
    assign free_count     = fl_count(tail, head);
    assign freelist_empty = (free_count == '0);
    assign alloc_preg     = mem[head[FL_IDX_W-1:0]];

    assign do_push = commit_valid && commit_has_rd;
    assign do_pop  = alloc_req && !freelist_empty && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++)
                mem[i] <= preg_t'(NUM_AREGS + i);
            head     <= '0;
            cmt_head <= '0;
            tail     <= FL_PTR_FULL;
        end else begin
            if (do_push) begin
                mem[tail[FL_IDX_W-1:0]] <= commit_old_preg;
                tail                    <= fl_ptr_inc(tail);
                cmt_head                <= fl_ptr_inc(cmt_head);
            end
            // A commit in the flush cycle has already consumed its pop, so
            // head lands one past the current committed head.
            if (flush)
                head <= do_push ? fl_ptr_inc(cmt_head) : cmt_head;
            else if (do_pop)
                head <= fl_ptr_inc(head);
        end
    end

endmodule
